period_capture: RTL and testbench

//   Measures the interval, in clk cycles, between consecutive rising edges of an asynchronous input.
//   - Is the reader counterpart to Counter: Counter generates counts and events, this block turns

---
 rtl/period_capture_pkg.sv | 16 +
 rtl/period_capture_if.sv | 22 ++
 rtl/sync_bit.sv | 24 ++
 rtl/period_capture.sv | 155 +++++++++++++++
 tb/tb_period_capture.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/period_capture_pkg.sv
// Shared types and helpers for the period_capture block: FSM encodings and
// the counter ceiling used for saturation.
package period_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    // All-ones value of a counter 'width' bits wide (1..32).
    function automatic logic [31:0] count_max(input int unsigned width);
        count_max = 32'hFFFF_FFFF >> (32'd32 - width);
    endfunction

endpackage

// File: rtl/period_capture_if.sv
// Consumer-side bundle of period_capture: buffered measurement with
// valid/ready handshake plus saturation and overrun status.
interface period_capture_if #(
    parameter int COUNT_WIDTH = 16
);
    logic [COUNT_WIDTH-1:0] period;
    logic                   period_valid;
    logic                   period_ready;
    logic                   saturated;
    logic                   overrun;
    logic                   clr_overrun;

    modport master (
        output period, period_valid, saturated, overrun,
        input  period_ready, clr_overrun
    );

    modport slave (
        input  period, period_valid, saturated, overrun,
        output period_ready, clr_overrun
    );
endinterface

// File: rtl/sync_bit.sv
// Flop-chain synchroniser for a single asynchronous bit; chain clears on reset.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_r;

    // shift the asynchronous input through the metastability chain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain_r <= '0;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
        end
    end

    assign q = chain_r[STAGES-1];

endmodule

// File: rtl/period_capture.sv
// Measures clk cycles between rising edges of sig_in and hands each interval
// to a consumer through a one-entry buffer with saturation and overrun flags.
module period_capture
    import period_capture_pkg::*;
#(
    parameter int COUNT_WIDTH = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  sig_in,
    period_capture_if.master      cap
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = COUNT_WIDTH'(count_max(COUNT_WIDTH));
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    logic                   s_s;
    logic                   s_d_r;
    logic                   edge_r;
    state_t                 state_r;
    state_t                 state_s;
    logic [COUNT_WIDTH-1:0] cnt_r;
    logic                   cnt_clr_s;
    logic                   cnt_load_s;
    logic                   cnt_inc_s;
    logic                   result_s;
    logic                   consume_s;
    logic                   load_s;
    logic                   drop_s;
    logic [COUNT_WIDTH-1:0] period_r;
    logic                   valid_r;
    logic                   sat_r;
    logic                   overrun_r;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sig_in),
        .q   (s_s)
    );

    // registered rising-edge detect on the synchronised input
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_d_r  <= 1'b0;
            edge_r <= 1'b0;
        end else begin
            s_d_r  <= s_s;
            edge_r <= s_s & ~s_d_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state; enable low overrides everything
    always_comb begin
        state_s = state_r;
        if (!enable) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:    state_s = ST_WAIT;
                ST_WAIT:    state_s = edge_r ? ST_MEASURE : ST_WAIT;
                ST_MEASURE: state_s = ST_MEASURE;
                default:    state_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: counter control and result strobe
    always_comb begin
        cnt_clr_s  = 1'b0;
        cnt_load_s = 1'b0;
        cnt_inc_s  = 1'b0;
        result_s   = 1'b0;
        if (!enable) begin
            cnt_clr_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: cnt_clr_s = 1'b1;
                ST_WAIT: cnt_load_s = edge_r;
                ST_MEASURE: begin
                    cnt_load_s = edge_r;
                    cnt_inc_s  = ~edge_r;
                    result_s   = edge_r;
                end
                default: cnt_clr_s = 1'b1;
            endcase
        end
    end

    // interval counter, restarts at 1 on each edge so the result equals t1 - t0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (cnt_clr_s) begin
            cnt_r <= '0;
        end else if (cnt_load_s) begin
            cnt_r <= CNT_ONE;
        end else if (cnt_inc_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign consume_s = valid_r & cap.period_ready;
    assign load_s    = result_s & (~valid_r | cap.period_ready);
    assign drop_s    = result_s & valid_r & ~cap.period_ready;

    // one-entry output buffer; a same-cycle consume frees the slot for the new result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_r <= '0;
            sat_r    <= 1'b0;
            valid_r  <= 1'b0;
        end else if (load_s) begin
            period_r <= cnt_r;
            sat_r    <= (cnt_r == CNT_MAX);
            valid_r  <= 1'b1;
        end else if (consume_s) begin
            valid_r  <= 1'b0;
        end else begin
            valid_r  <= valid_r;
        end
    end

    // sticky overrun; a new drop beats a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end else if (cap.clr_overrun) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign cap.period       = period_r;
    assign cap.period_valid = valid_r;
    assign cap.saturated    = sat_r;
    assign cap.overrun      = overrun_r;

endmodule

// File: tb/tb_period_capture.sv
// Drives two period_capture instances (16-bit and 4-bit counters) with the same
// randomized edge trains and checks every delivered interval against the edge spacing.
module tb_period_capture;

    localparam int MAX4 = 15;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic sig_in;
    logic ready;
    logic clr;

    period_capture_if #(.COUNT_WIDTH(16)) bus16 ();
    period_capture_if #(.COUNT_WIDTH(4))  bus4 ();

    assign bus16.period_ready = ready;
    assign bus16.clr_overrun  = clr;
    assign bus4.period_ready  = ready;
    assign bus4.clr_overrun   = clr;

    period_capture #(.COUNT_WIDTH(16), .SYNC_STAGES(2)) dut16 (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .sig_in (sig_in),
        .cap    (bus16)
    );

    period_capture #(.COUNT_WIDTH(4), .SYNC_STAGES(2)) dut4 (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .sig_in (sig_in),
        .cap    (bus4)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int gaps[$];
    int exp_q[$];
    int got16[$];
    int got4[$];
    bit gs16[$];
    bit gs4[$];
    int g16, g4, e4;
    bit s16, s4;

    // record every accepted handshake, sampled half a cycle before the transfer edge
    always @(negedge clk) begin
        if (rst && bus16.period_valid && bus16.period_ready) begin
            got16.push_back(int'(bus16.period));
            gs16.push_back(bus16.saturated);
        end
        if (rst && bus4.period_valid && bus4.period_ready) begin
            got4.push_back(int'(bus4.period));
            gs4.push_back(bus4.saturated);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // one rising edge, next rise exactly 'gap' cycles later, random high time
    task automatic edge_gap(input int gap);
        int h;
        h = int'($urandom_range(gap - 1, 1));
        gaps.push_back(gap);
        sig_in = 1'b1;
        tick(h);
        sig_in = 1'b0;
        tick(gap - h);
    endtask

    task automatic clear_queues();
        gaps.delete();
        exp_q.delete();
        got16.delete();
        got4.delete();
        gs16.delete();
        gs4.delete();
    endtask

    task automatic restart();
        enable = 1'b0;
        tick(3);
        enable = 1'b1;
        tick(2);
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; sig_in = 1'b0; ready = 1'b0; clr = 1'b0;
        tick(3);
        checks++;
        if ({bus16.period, bus16.period_valid, bus16.saturated, bus16.overrun} !== 19'd0) begin
            errors++;
            $display("FAIL reset16: got %0h expected 0", {bus16.period, bus16.period_valid, bus16.saturated, bus16.overrun});
        end
        checks++;
        if ({bus4.period, bus4.period_valid, bus4.saturated, bus4.overrun} !== 7'd0) begin
            errors++;
            $display("FAIL reset4: got %0h expected 0", {bus4.period, bus4.period_valid, bus4.saturated, bus4.overrun});
        end
        rst = 1'b1;
        tick(2);
    endtask

    task automatic test_square();
        restart();
        clear_queues();
        ready = 1'b1;
        edge_gap(10);
        checks++;
        if (got16.size() != 0) begin
            errors++;
            $display("FAIL square first_edge: got %0d results expected 0", got16.size());
        end
        repeat (5) edge_gap(10);
        tick(8);
        for (int i = 0; i < gaps.size() - 1; i++) exp_q.push_back(gaps[i]);
        checks++;
        if (got16.size() != exp_q.size() || got4.size() != exp_q.size()) begin
            errors++;
            $display("FAIL square count: got %0d/%0d expected %0d", got16.size(), got4.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            g16 = (i < got16.size()) ? got16[i] : -1;
            s16 = (i < gs16.size()) ? gs16[i] : 1'b1;
            checks++;
            if (g16 !== exp_q[i] || s16 !== 1'b0) begin
                errors++;
                $display("FAIL square p16[%0d]: got %0d sat %0d expected %0d sat 0", i, g16, s16, exp_q[i]);
            end
        end
    endtask

    task automatic test_saturation();
        restart();
        clear_queues();
        ready = 1'b1;
        edge_gap(20);
        edge_gap(7);
        edge_gap(10);
        tick(8);
        for (int i = 0; i < gaps.size() - 1; i++) exp_q.push_back(gaps[i]);
        checks++;
        if (got16.size() != exp_q.size() || got4.size() != exp_q.size()) begin
            errors++;
            $display("FAIL sat count: got %0d/%0d expected %0d", got16.size(), got4.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            g16 = (i < got16.size()) ? got16[i] : -1;
            g4  = (i < got4.size()) ? got4[i] : -1;
            s4  = (i < gs4.size()) ? gs4[i] : 1'bx;
            e4  = (exp_q[i] >= MAX4) ? MAX4 : exp_q[i];
            checks++;
            if (g16 !== exp_q[i]) begin
                errors++;
                $display("FAIL sat p16[%0d]: got %0d expected %0d", i, g16, exp_q[i]);
            end
            checks++;
            if (g4 !== e4 || s4 !== (exp_q[i] >= MAX4)) begin
                errors++;
                $display("FAIL sat p4[%0d]: got %0d sat %0d expected %0d sat %0d", i, g4, s4, e4, exp_q[i] >= MAX4);
            end
        end
    endtask

    task automatic test_random();
        restart();
        clear_queues();
        ready = 1'b1;
        for (int i = 0; i < 14; i++) edge_gap((i == 3) ? 2 : int'($urandom_range(25, 2)));
        tick(8);
        for (int i = 0; i < gaps.size() - 1; i++) exp_q.push_back(gaps[i]);
        checks++;
        if (got16.size() != exp_q.size() || got4.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random count: got %0d/%0d expected %0d", got16.size(), got4.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            g16 = (i < got16.size()) ? got16[i] : -1;
            s16 = (i < gs16.size()) ? gs16[i] : 1'b1;
            g4  = (i < got4.size()) ? got4[i] : -1;
            s4  = (i < gs4.size()) ? gs4[i] : 1'bx;
            e4  = (exp_q[i] >= MAX4) ? MAX4 : exp_q[i];
            checks++;
            if (g16 !== exp_q[i] || s16 !== 1'b0) begin
                errors++;
                $display("FAIL random p16[%0d]: got %0d sat %0d expected %0d sat 0", i, g16, s16, exp_q[i]);
            end
            checks++;
            if (g4 !== e4 || s4 !== (exp_q[i] >= MAX4)) begin
                errors++;
                $display("FAIL random p4[%0d]: got %0d sat %0d expected %0d sat %0d", i, g4, s4, e4, exp_q[i] >= MAX4);
            end
        end
    endtask

    task automatic test_overrun();
        restart();
        clear_queues();
        ready = 1'b0;
        repeat (3) edge_gap(8);
        tick(8);
        checks++;
        if ({bus16.period, bus16.period_valid, bus16.saturated, bus16.overrun} !== {16'd8, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL overrun16: got p=%0d v=%0b s=%0b o=%0b expected p=8 v=1 s=0 o=1",
                     bus16.period, bus16.period_valid, bus16.saturated, bus16.overrun);
        end
        checks++;
        if ({bus4.period, bus4.period_valid, bus4.saturated, bus4.overrun} !== {4'd8, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL overrun4: got p=%0d v=%0b s=%0b o=%0b expected p=8 v=1 s=0 o=1",
                     bus4.period, bus4.period_valid, bus4.saturated, bus4.overrun);
        end
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(1);
        checks++;
        if ({bus16.period, bus16.period_valid, bus16.overrun} !== {16'd8, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL clr_overrun: got p=%0d v=%0b o=%0b expected p=8 v=1 o=0",
                     bus16.period, bus16.period_valid, bus16.overrun);
        end
    endtask

    task automatic test_buffer_race();
        restart();
        checks++;
        if (bus16.period_valid !== 1'b1 || bus16.period !== 16'd8) begin
            errors++;
            $display("FAIL disable_keeps_buffer: got p=%0d v=%0b expected p=8 v=1", bus16.period, bus16.period_valid);
        end
        clear_queues();
        edge_gap(12);
        sig_in = 1'b1;
        tick(3);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(1);
        sig_in = 1'b0;
        tick(8);
        checks++;
        if ({bus16.period, bus16.period_valid, bus16.overrun} !== {16'd12, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL race16: got p=%0d v=%0b o=%0b expected p=12 v=1 o=0",
                     bus16.period, bus16.period_valid, bus16.overrun);
        end
        checks++;
        if ({bus4.period, bus4.period_valid, bus4.overrun} !== {4'd12, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL race4: got p=%0d v=%0b o=%0b expected p=12 v=1 o=0",
                     bus4.period, bus4.period_valid, bus4.overrun);
        end
        ready = 1'b1;
        tick(2);
        g16 = (got16.size() == 2) ? got16[0] * 100 + got16[1] : -got16.size();
        checks++;
        if (g16 !== 812 || bus16.period_valid !== 1'b0) begin
            errors++;
            $display("FAIL race_drain: got code %0d v=%0b expected 812 (8 then 12) v=0", g16, bus16.period_valid);
        end
    endtask

    task automatic test_enable();
        restart();
        clear_queues();
        ready = 1'b1;
        edge_gap(6);
        edge_gap(6);
        tick(4);
        enable = 1'b0;
        tick(3);
        enable = 1'b1;
        tick(2);
        edge_gap(6);
        checks++;
        if (got16.size() != 1) begin
            errors++;
            $display("FAIL enable_first_edge: got %0d results expected 1", got16.size());
        end
        edge_gap(6);
        edge_gap(6);
        tick(8);
        exp_q = '{6, 6, 6};
        checks++;
        if (got16.size() != exp_q.size()) begin
            errors++;
            $display("FAIL enable count: got %0d expected %0d", got16.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            g16 = (i < got16.size()) ? got16[i] : -1;
            checks++;
            if (g16 !== exp_q[i]) begin
                errors++;
                $display("FAIL enable p16[%0d]: got %0d expected %0d", i, g16, exp_q[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        restart();
        clear_queues();
        ready = 1'b0;
        edge_gap(10);
        edge_gap(10);
        checks++;
        if (bus16.period_valid !== 1'b1 || bus16.period !== 16'd10) begin
            errors++;
            $display("FAIL prereset: got p=%0d v=%0b expected p=10 v=1", bus16.period, bus16.period_valid);
        end
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({bus16.period, bus16.period_valid, bus16.saturated, bus16.overrun} !== 19'd0) begin
            errors++;
            $display("FAIL async_reset16: got %0h expected 0", {bus16.period, bus16.period_valid, bus16.saturated, bus16.overrun});
        end
        checks++;
        if ({bus4.period, bus4.period_valid, bus4.saturated, bus4.overrun} !== 7'd0) begin
            errors++;
            $display("FAIL async_reset4: got %0h expected 0", {bus4.period, bus4.period_valid, bus4.saturated, bus4.overrun});
        end
        @(posedge clk);
        #1 rst = 1'b1;
        tick(2);
        clear_queues();
        ready = 1'b1;
        repeat (3) edge_gap(9);
        tick(8);
        g16 = (got16.size() == 2) ? got16[0] * 100 + got16[1] : -got16.size();
        checks++;
        if (g16 !== 909) begin
            errors++;
            $display("FAIL post_reset: got code %0d expected 909 (two results of 9)", g16);
        end
    endtask

    initial begin
        test_reset();
        test_square();
        test_saturation();
        test_random();
        test_overrun();
        test_buffer_race();
        test_enable();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
